ahfp_div: RTL and testbench

//  Multi-cycle IEEE-754 single-precision divider: result = dataa / datab.

---
 rtl/ahfp_pkg.sv | 24 ++
 rtl/ahfp_div_step.sv | 22 ++
 rtl/ahfp_div.sv | 133 +++++++++++++
 tb/tb_ahfp_div.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ahfp_pkg.sv
// Shared constants and FSM encoding for the single-precision FP divider.
package ahfp_pkg;

    localparam int BIAS  = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int QBITS = 26;

    localparam logic [EXP_W-1:0] EXP_INF  = 8'hFF;
    localparam logic [MAN_W-1:0] QNAN_MAN = 23'h400000;

    // state     | meaning
    // ST_IDLE   | waiting for start, result held
    // ST_DIVIDE | restoring steps, STEPS_PER_CYCLE per clock
    // ST_ROUND  | normalise, round, special cases; result register loaded
    // ST_DONE   | done pulse for one enabled cycle
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ahfp_div_step.sv
// One restoring division step: conditional subtract of the divisor, then shift left.
module ahfp_div_step
    import ahfp_pkg::*;
(
    input  logic [MAN_W+1:0] i_rem,
    input  logic [MAN_W:0]   i_div,
    output logic [MAN_W+1:0] o_rem,
    output logic             o_qbit
);

    logic             w_ge;
    logic [MAN_W+1:0] w_diff;
    logic [MAN_W+1:0] w_sel;

    assign w_ge   = (i_rem >= {1'b0, i_div});
    assign w_diff = i_rem - {1'b0, i_div};
    assign w_sel  = w_ge ? w_diff : i_rem;
    // After a restoring step rem < divisor < 2^24, so the shift never loses a bit.
    assign o_rem  = {w_sel[MAN_W:0], 1'b0};
    assign o_qbit = w_ge;

endmodule

// File: rtl/ahfp_div.sv
// Multi-cycle IEEE-754 single-precision divider (result = dataa / datab), start/done handshake.
module ahfp_div #(
    parameter int BIAS            = ahfp_pkg::BIAS,
    parameter int STEPS_PER_CYCLE = 1,
    parameter int QBITS           = ahfp_pkg::QBITS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result
);
    import ahfp_pkg::*;

    localparam int S     = STEPS_PER_CYCLE;
    localparam int N_CYC = QBITS / S;
    localparam int CNT_W = $clog2(N_CYC + 1);

    state_t             r_state;
    logic [MAN_W+1:0]   r_rem;
    logic [MAN_W:0]     r_mb;
    logic [QBITS-1:0]   r_q;
    logic [EXP_W-1:0]   r_ea;
    logic [EXP_W-1:0]   r_eb;
    logic               r_zs;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [31:0]        r_result;

    logic [S:0][MAN_W+1:0] w_rem;
    logic [S-1:0]          w_qbits;

    assign w_rem[0] = r_rem;

    // First step in the chain produces the more significant quotient bit.
    for (genvar g = 0; g < S; g++) begin : g_step
        ahfp_div_step u_step (
            .i_rem  (w_rem[g]),
            .i_div  (r_mb),
            .o_rem  (w_rem[g+1]),
            .o_qbit (w_qbits[S-1-g])
        );
    end

    logic               w_int;
    logic [MAN_W-1:0]   w_mant;
    logic               w_rbit;
    logic signed [9:0]  w_exp_norm;
    logic [MAN_W:0]     w_mant_rnd;
    logic signed [9:0]  w_exp_fin;
    logic [MAN_W-1:0]   w_man_fin;
    logic [31:0]        w_res;

    assign w_int  = r_q[QBITS-1];
    assign w_mant = w_int ? r_q[QBITS-2:2] : r_q[QBITS-3:1];
    assign w_rbit = w_int ? r_q[1] : r_q[0];

    // Exponent kept in 10-bit two's complement so over/underflow is visible.
    assign w_exp_norm = {2'b00, r_ea} - {2'b00, r_eb} + 10'(BIAS) - {9'd0, ~w_int};
    assign w_mant_rnd = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_rbit};
    assign w_exp_fin  = w_exp_norm + {9'd0, w_mant_rnd[MAN_W]};
    assign w_man_fin  = w_mant_rnd[MAN_W] ? '0 : w_mant_rnd[MAN_W-1:0];

    always_comb begin
        w_res = {r_zs, w_exp_fin[EXP_W-1:0], w_man_fin};
        if (r_ea == '0 && r_eb == '0) begin
            w_res = {r_zs, EXP_INF, QNAN_MAN};
        end else if (r_eb == '0) begin
            w_res = {r_zs, EXP_INF, {MAN_W{1'b0}}};
        end else if (r_ea == '0) begin
            w_res = {r_zs, 31'h0};
        end else if (w_exp_fin >= 10'sd255) begin
            w_res = {r_zs, EXP_INF, {MAN_W{1'b0}}};
        end else if (w_exp_fin <= 10'sd0) begin
            w_res = {r_zs, 31'h0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_rem    <= '0;
            r_mb     <= '0;
            r_q      <= '0;
            r_ea     <= '0;
            r_eb     <= '0;
            r_zs     <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (clk_en) begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rem   <= {2'b01, dataa[MAN_W-1:0]};
                        r_mb    <= {1'b1, datab[MAN_W-1:0]};
                        r_ea    <= dataa[30:23];
                        r_eb    <= datab[30:23];
                        r_zs    <= dataa[31] ^ datab[31];
                        r_q     <= '0;
                        r_cnt   <= CNT_W'(N_CYC - 1);
                        r_state <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    r_rem <= w_rem[S];
                    r_q   <= {r_q[QBITS-1-S:0], w_qbits};
                    if (r_cnt == '0) begin
                        r_state <= ST_ROUND;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ROUND: begin
                    r_result <= w_res;
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_ahfp_div.sv
// Directed bench for ahfp_div: one- and two-step-per-cycle instances driven in parallel.
module tb_ahfp_div;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done1;
    logic        done2;
    logic [31:0] res1;
    logic [31:0] res2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ahfp_div #(.STEPS_PER_CYCLE(1)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .start   (start),
        .dataa   (dataa),
        .datab   (datab),
        .done    (done1),
        .result  (res1)
    );

    ahfp_div #(.STEPS_PER_CYCLE(2)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .start   (start),
        .dataa   (dataa),
        .datab   (datab),
        .done    (done2),
        .result  (res2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Cycle 1 is the cycle right after the accepting edge; latency is the cycle done is seen high.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_r, input int lat1_exp, input int lat2_exp,
                           input int restart_at, input int freeze_at);
        int          cyc;
        int          lat1;
        int          lat2;
        logic [31:0] r1;
        logic [31:0] r2;
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc  = 1;
        lat1 = 0;
        lat2 = 0;
        r1   = '0;
        r2   = '0;
        while ((lat1 == 0 || lat2 == 0) && cyc <= 100) begin
            if (done1 && lat1 == 0) begin lat1 = cyc; r1 = res1; end
            if (done2 && lat2 == 0) begin lat2 = cyc; r2 = res2; end
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                dataa = 32'h3F800000;
                datab = 32'h40400000;
            end
            clk_en = !(freeze_at > 0 && cyc >= freeze_at && cyc < freeze_at + 5);
            if (lat1 == 0 || lat2 == 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        start  = 1'b0;
        clk_en = 1'b1;
        check({tag, "/res1"}, r1, exp_r);
        check({tag, "/lat1"}, 32'(lat1), 32'(lat1_exp));
        check({tag, "/res2"}, r2, exp_r);
        check({tag, "/lat2"}, 32'(lat2), 32'(lat2_exp));
        @(negedge clk);
        check({tag, "/pulse"}, {31'd0, done1}, 32'd0);
        check({tag, "/hold"}, res1, exp_r);
    endtask

    initial begin
        reset_n = 1'b0;
        clk_en  = 1'b1;
        start   = 1'b0;
        dataa   = '0;
        datab   = '0;
        repeat (3) @(negedge clk);
        check("rst/done1", {31'd0, done1}, 32'd0);
        check("rst/res1", res1, 32'd0);
        check("rst/done2", {31'd0, done2}, 32'd0);
        check("rst/res2", res2, 32'd0);
        reset_n = 1'b1;

        run_div("6_2",    32'h40C00000, 32'h40000000, 32'h40400000, 28, 15, 0, 0);
        run_div("1_3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, 15, 0, 0);
        run_div("m1_3",   32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 28, 15, 0, 0);
        run_div("m75_25", 32'hC0F00000, 32'h40200000, 32'hC0400000, 28, 15, 0, 0);
        run_div("1_0",    32'h3F800000, 32'h00000000, 32'h7F800000, 28, 15, 0, 0);
        run_div("nz_2",   32'h80000000, 32'h40000000, 32'h80000000, 28, 15, 0, 0);
        run_div("ovf",    32'h7F000000, 32'h00800000, 32'h7F800000, 28, 15, 0, 0);
        run_div("unf",    32'h00800000, 32'h40000000, 32'h00000000, 28, 15, 0, 0);
        run_div("nan",    32'h00000000, 32'h00000000, 32'h7FC00000, 28, 15, 0, 0);
        run_div("restart",32'h40C00000, 32'h40000000, 32'h40400000, 28, 15, 5, 0);
        run_div("freeze", 32'hC0F00000, 32'h40200000, 32'hC0400000, 33, 20, 0, 3);

        @(negedge clk);
        dataa = 32'h3F800000;
        datab = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst/done1", {31'd0, done1}, 32'd0);
        check("midrst/res1", res1, 32'd0);
        check("midrst/res2", res2, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_div("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 28, 15, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
